// File: rtl/ks_data_path_param.sv
// Parametrised K&S datapath: PC, IR, decoder, register file, 4-op ALU and
// a registered flags set. All sequencing comes from the external control FSM.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_HALT   = 4'd11
  } decoded_instruction_type;
endpackage

module ks_data_path_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [DATA_W-1:0]       data_in,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out
);

  // A single-entry file still needs a one-bit select field.
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Register and address fields must fit below the 8-bit opcode.
  generate
    if ((ADDR_W + RW > DATA_W - 8) || (3 * RW > DATA_W - 8)) begin : g_bad_params
      $error("ks_data_path_param: illegal DATA_W/ADDR_W/NUM_REGS combination");
    end
  endgenerate

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic [7:0]        opcode;
  logic [RW-1:0]     reg_a;
  logic [RW-1:0]     reg_b;
  logic [RW-1:0]     reg_c;
  logic [ADDR_W-1:0] mem_addr;
  decoded_instruction_type dec;

  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        flags_next;

  // Only some IR bits feed the decoder; fold the rest so they count as consumed.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir;

  // Flag set {zero, neg, carry/borrow, signed overflow} from ALU operands and result.
  // Logic ops never report carry or signed overflow.
  function automatic logic [3:0] calc_flags(input logic [1:0]        op,
                                            input logic              a_msb,
                                            input logic              b_msb,
                                            input logic [DATA_W-1:0] r,
                                            input logic              cy);
    logic ovf;
    logic c_out;
    ovf   = 1'b0;
    c_out = 1'b0;
    case (op)
      2'b00: begin
        ovf   = (a_msb == b_msb) && (r[DATA_W-1] != a_msb);
        c_out = cy;
      end
      2'b01: begin
        ovf   = (a_msb != b_msb) && (r[DATA_W-1] != a_msb);
        c_out = cy;
      end
      default: begin
        ovf   = 1'b0;
        c_out = 1'b0;
      end
    endcase
    return {(r == '0), r[DATA_W-1], c_out, ovf};
  endfunction

  assign opcode = ir[DATA_W-1 -: 8];

  // Instruction decode; every output defaults so unknown opcodes fall to NOP.
  always_comb begin
    dec      = I_NOP;
    reg_a    = '0;
    reg_b    = '0;
    reg_c    = '0;
    mem_addr = '0;
    case (opcode)
      8'h81: begin
        dec      = I_LOAD;
        reg_c    = ir[ADDR_W+RW-1:ADDR_W];
        mem_addr = ir[ADDR_W-1:0];
      end
      8'h82: begin
        dec      = I_STORE;
        reg_a    = ir[ADDR_W+RW-1:ADDR_W];
        mem_addr = ir[ADDR_W-1:0];
      end
      8'h91: begin
        dec   = I_MOVE;
        reg_a = ir[RW-1:0];
        reg_b = ir[RW-1:0];
        reg_c = ir[2*RW-1:RW];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        dec   = (opcode == 8'hA1) ? I_ADD :
                (opcode == 8'hA2) ? I_SUB :
                (opcode == 8'hA3) ? I_AND : I_OR;
        reg_a = ir[RW-1:0];
        reg_b = ir[2*RW-1:RW];
        reg_c = ir[3*RW-1:2*RW];
      end
      8'h01: begin
        dec      = I_BRANCH;
        mem_addr = ir[ADDR_W-1:0];
      end
      8'h02: begin
        dec      = I_BZERO;
        mem_addr = ir[ADDR_W-1:0];
      end
      8'h03: begin
        dec      = I_BNEG;
        mem_addr = ir[ADDR_W-1:0];
      end
      8'hFF:   dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  assign decoded_instruction = dec;

  assign bus_a    = rf[reg_a];
  assign bus_b    = rf[reg_b];
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? mem_addr : pc;

  // Carry and borrow both fall out of the extra top bit of a zero-extended add/sub.
  assign sum  = {1'b0, bus_a} + {1'b0, bus_b};
  assign diff = {1'b0, bus_a} - {1'b0, bus_b};

  // ALU result select; result is truncated to DATA_W.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (operation)
      2'b00: begin
        alu_result = sum[DATA_W-1:0];
        alu_carry  = sum[DATA_W];
      end
      2'b01: begin
        alu_result = diff[DATA_W-1:0];
        alu_carry  = diff[DATA_W];
      end
      2'b10:   alu_result = bus_a & bus_b;
      default: alu_result = bus_a | bus_b;
    endcase
  end

  assign flags_next = calc_flags(operation, bus_a[DATA_W-1], bus_b[DATA_W-1],
                                 alu_result, alu_carry);
  assign wb_data    = c_sel ? alu_result : data_in;

  // Program counter: branch target or increment, wrapping at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_enable) begin
      pc <= branch ? mem_addr : pc + ADDR_W'(1);
    end
  end

  // Instruction register; decode of the old value drives this cycle's updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
    end else if (ir_enable) begin
      ir <= data_in;
    end
  end

  // Register file write port; reads are combinational and see the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (write_reg_enable) begin
      rf[reg_c] <= wb_data;
    end
  end

  // Flags register; outputs are only ever the stored copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      {zero_op, neg_op, unsigned_overflow, signed_overflow} <= 4'b0000;
    end else if (flags_reg_enable) begin
      {zero_op, neg_op, unsigned_overflow, signed_overflow} <= flags_next;
    end
  end

endmodule

// File: tb/tb_ks_data_path_param.sv
// Self-checking bench for ks_data_path_param: default 16/5/4 instance plus a
// 24/8/8 instance for the wide-parameter case.

module tb_ks_data_path_param;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable;
  logic [15:0] data_in;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;

  logic w_branch, w_pc_enable, w_ir_enable, w_addr_sel, w_c_sel;
  logic [1:0] w_operation;
  logic w_we, w_fe;
  logic [23:0] w_data_in;
  decoded_instruction_type w_dec;
  logic w_zero, w_neg, w_uov, w_sov;
  logic [7:0]  w_ram_addr;
  logic [23:0] w_data_out;

  ks_data_path_param #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(4)) u_dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .data_in(data_in),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr), .data_out(data_out)
  );

  ks_data_path_param #(.DATA_W(24), .ADDR_W(8), .NUM_REGS(8)) u_wide (
    .clk(clk), .rst(rst), .branch(w_branch), .pc_enable(w_pc_enable),
    .ir_enable(w_ir_enable), .addr_sel(w_addr_sel), .c_sel(w_c_sel),
    .operation(w_operation), .write_reg_enable(w_we),
    .flags_reg_enable(w_fe), .data_in(w_data_in),
    .decoded_instruction(w_dec), .zero_op(w_zero),
    .neg_op(w_neg), .unsigned_overflow(w_uov),
    .signed_overflow(w_sov), .ram_addr(w_ram_addr), .data_out(w_data_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;   // {zero, neg, carry/borrow, signed overflow}
  } alu_vec_t;

  alu_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; addr_sel = 1'b0;
    c_sel = 1'b0; operation = 2'b00; write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
  endtask

  task automatic set_ir(input logic [15:0] v);
    data_in   = v;
    ir_enable = 1'b1;
    tick();
    ir_enable = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
    set_ir(16'h8100 | (16'(r) << 5));
    data_in = v;
    c_sel = 1'b0;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
    set_ir(16'h8200 | (16'(r) << 5));
    v = data_out;
  endtask

  task automatic run_alu(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rc, input logic fe);
    set_ir({8'hA1 + {6'b0, op}, 2'b00, rc, rb, ra});
    operation = op;
    c_sel = 1'b1;
    write_reg_enable = 1'b1;
    flags_reg_enable = fe;
    tick();
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f);
    int unsigned ua, ub;
    int sa, sb, s;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      2'd0: begin
        r = 16'(ua + ub); c = (ua + ub) > 32'd65535;
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        r = 16'(ua - ub); c = ua < ub;
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    f = {(r == 16'd0), r[15], c, v};
  endfunction

  function automatic logic [3:0] flags_now();
    return {zero_op, neg_op, unsigned_overflow, signed_overflow};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v, r_exp;
    logic [3:0]  f_exp;
    logic [15:0] ra, rb;
    logic [1:0]  rop;

    vecs[0] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    vecs[2] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 4'b1011};
    vecs[3] = '{2'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110};
    vecs[4] = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    vecs[5] = '{2'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1000};
    vecs[6] = '{2'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vecs[7] = '{2'd3, 16'h8000, 16'h0001, 16'h8001, 4'b0100};
    vecs[8] = '{2'd2, 16'hAAAA, 16'h5555, 16'h0000, 4'b1000};
    vecs[9] = '{2'd1, 16'h0000, 16'h8000, 16'h8000, 4'b0111};

    idle();
    data_in = 16'h0000;
    w_branch = 0; w_pc_enable = 0; w_ir_enable = 0; w_addr_sel = 0;
    w_c_sel = 0; w_operation = 0; w_we = 0; w_fe = 0; w_data_in = '0;
    rst = 1'b1;
    tick(); tick();

    // reset with every enable asserted
    branch = 1; pc_enable = 1; ir_enable = 1; c_sel = 1; operation = 2'b00;
    write_reg_enable = 1; flags_reg_enable = 1; data_in = 16'hFFFF;
    tick();
    rst = 1'b0;
    idle();
    data_in = 16'h0000;
    check("rst_pc", 32'(ram_addr), 32'd0);
    check("rst_flags", 32'(flags_now()), 32'd0);
    check("rst_decode", 32'(decoded_instruction), 32'(I_NOP));
    check("rst_data_out", 32'(data_out), 32'd0);
    addr_sel = 1'b1;
    #1 check("rst_mem_addr", 32'(ram_addr), 32'd0);
    addr_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check($sformatf("rst_rf%0d", i), 32'(v), 32'd0);
    end

    // PC increments and wraps 31 -> 0
    for (int i = 1; i <= 33; i++) begin
      pc_enable = 1'b1;
      tick();
      check($sformatf("pc_inc%0d", i), 32'(ram_addr), 32'(i % 32));
    end
    pc_enable = 1'b0;
    tick();
    check("pc_hold", 32'(ram_addr), 32'd1);
    set_ir(16'h0117);
    check("dec_branch", 32'(decoded_instruction), 32'(I_BRANCH));
    branch = 1'b1; pc_enable = 1'b1;
    tick();
    check("pc_branch", 32'(ram_addr), 32'd23);
    branch = 1'b0;
    tick();
    check("pc_after_branch", 32'(ram_addr), 32'd24);
    // IR load coinciding with a branch uses the old target
    data_in = 16'h0105; ir_enable = 1'b1; branch = 1'b1;
    tick();
    ir_enable = 1'b0;
    check("pc_old_decode", 32'(ram_addr), 32'd23);
    tick();
    check("pc_new_decode", 32'(ram_addr), 32'd5);
    idle();

    // LOAD / STORE
    set_ir(16'h8145);
    check("dec_load", 32'(decoded_instruction), 32'(I_LOAD));
    addr_sel = 1'b1;
    #1 check("load_addr", 32'(ram_addr), 32'd5);
    data_in = 16'h1234; c_sel = 1'b0; write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    set_ir(16'h8245);
    check("dec_store", 32'(decoded_instruction), 32'(I_STORE));
    check("store_data", 32'(data_out), 32'h1234);
    check("store_addr", 32'(ram_addr), 32'd5);
    addr_sel = 1'b0;
    set_ir(16'h5500);
    check("dec_unknown", 32'(decoded_instruction), 32'(I_NOP));
    set_ir(16'hFF00);
    check("dec_halt", 32'(decoded_instruction), 32'(I_HALT));

    // Table of ALU vectors: R2 = R0 op R1
    for (int i = 0; i < 10; i++) begin
      write_reg(2'd0, vecs[i].a);
      write_reg(2'd1, vecs[i].b);
      run_alu(vecs[i].op, 2'd0, 2'd1, 2'd2, 1'b1);
      check($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(vecs[i].f));
      read_reg(2'd2, v);
      check($sformatf("vec%0d_result", i), 32'(v), 32'(vecs[i].r));
    end

    // ADD overflow via literal instruction A1B4: R3 = R0 + R1
    write_reg(2'd0, 16'h7FFF);
    write_reg(2'd1, 16'h0001);
    set_ir(16'hA1B4);
    check("dec_add", 32'(decoded_instruction), 32'(I_ADD));
    operation = 2'b00; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
    tick();
    idle();
    check("addovf_flags", 32'(flags_now()), 32'b0101);
    read_reg(2'd3, v);
    check("addovf_r3", 32'(v), 32'h8000);

    // SUB then R1-R1 for zero, then flags hold with load disabled
    write_reg(2'd0, 16'd3);
    write_reg(2'd1, 16'd5);
    run_alu(2'd1, 2'd0, 2'd1, 2'd2, 1'b1);
    check("sub_flags", 32'(flags_now()), 32'b0110);
    read_reg(2'd2, v);
    check("sub_r2", 32'(v), 32'hFFFE);
    run_alu(2'd1, 2'd1, 2'd1, 2'd3, 1'b1);
    check("subzero_flags", 32'(flags_now()), 32'b1000);
    run_alu(2'd0, 2'd0, 2'd1, 2'd3, 1'b0);
    check("flags_hold", 32'(flags_now()), 32'b1000);
    read_reg(2'd3, v);
    check("hold_r3", 32'(v), 32'd8);

    // MOVE R2 <- R1 (issued as OR with a=b)
    set_ir(16'h9109);
    check("dec_move", 32'(decoded_instruction), 32'(I_MOVE));
    operation = 2'b11; c_sel = 1'b1; write_reg_enable = 1'b1;
    tick();
    idle();
    read_reg(2'd2, v);
    check("move_r2", 32'(v), 32'd5);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = (i % 5 == 0) ? ra : 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      model(rop, ra, rb, r_exp, f_exp);
      write_reg(2'd0, ra);
      write_reg(2'd1, rb);
      run_alu(rop, 2'd0, 2'd1, 2'd2, 1'b1);
      check($sformatf("rnd%0d_flags", i), 32'(flags_now()), 32'(f_exp));
      read_reg(2'd2, v);
      check($sformatf("rnd%0d_result", i), 32'(v), 32'(r_exp));
    end

    // Reset in the middle of an instruction leaves nothing behind
    write_reg(2'd0, 16'h7FFF);
    write_reg(2'd1, 16'h0001);
    set_ir(16'hA1B4);
    operation = 2'b00; c_sel = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
    pc_enable = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("midrst_flags", 32'(flags_now()), 32'd0);
    check("midrst_pc", 32'(ram_addr), 32'd0);
    check("midrst_decode", 32'(decoded_instruction), 32'(I_NOP));
    read_reg(2'd3, v);
    check("midrst_r3", 32'(v), 32'd0);
    read_reg(2'd0, v);
    check("midrst_r0", 32'(v), 32'd0);

    // Wide instance: ADD R7 = R5 + R6 with 3-bit fields
    w_data_in = 24'h810500; w_ir_enable = 1; tick(); w_ir_enable = 0;
    w_data_in = 24'h7FFFFF; w_c_sel = 0; w_we = 1; tick(); w_we = 0;
    w_data_in = 24'h810600; w_ir_enable = 1; tick(); w_ir_enable = 0;
    w_data_in = 24'h000001; w_we = 1; tick(); w_we = 0;
    w_data_in = 24'hA101F5; w_ir_enable = 1; tick(); w_ir_enable = 0;
    w_operation = 2'b00; w_c_sel = 1; w_we = 1; w_fe = 1; tick(); w_we = 0; w_fe = 0;
    w_data_in = 24'h8207AB; w_ir_enable = 1; tick(); w_ir_enable = 0;
    w_addr_sel = 1'b1;
    #1;
    check("wide_dec", 32'(w_dec), 32'(I_STORE));
    check("wide_r7", 32'(w_data_out), 32'h800000);
    check("wide_addr", 32'(w_ram_addr), 32'hAB);
    check("wide_flags", 32'({w_zero, w_neg, w_uov, w_sov}), 32'b0101);
    w_data_in = 24'h820500; w_ir_enable = 1; tick(); w_ir_enable = 0;
    check("wide_r5", 32'(w_data_out), 32'h7FFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_data_path_param.md
Name: ks_data_path_param

Overview:
Parametrised next-generation K&S datapath: PC, IR, instruction decoder, NUM_REGS-entry register file, 4-op ALU and a stored flags register. It sits between the external K&S control FSM, which drives all enables and selects, and a single-port instruction/data RAM. It generalises data width, RAM address width and register count, and adds the STORE path, reset of all state and registered flags.

Parameters:
DATA_W, 16, data/instruction width; opcode is always IR[DATA_W-1:DATA_W-8]
ADDR_W, 5, RAM address width; also the PC width
NUM_REGS, 4, register file depth; RW = $clog2(NUM_REGS) bits per register field
Legal combinations: ADDR_W+RW <= DATA_W-8 and 3*RW <= DATA_W-8; elaboration $error otherwise.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
branch  in  1  PC load select: 1 = mem_addr, 0 = PC+1
pc_enable  in  1  PC update strobe
ir_enable  in  1  IR load from data_in
addr_sel  in  1  ram_addr select: 1 = decoded mem_addr, 0 = PC
c_sel  in  1  write-back select: 1 = ALU result, 0 = data_in
operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
write_reg_enable  in  1  register file write strobe
flags_reg_enable  in  1  flags register load strobe
data_in  in  DATA_W  RAM read data
decoded_instruction  out  decoded_instruction_type  current IR decode (k_and_s_pkg)
zero_op  out  1  registered zero flag
neg_op  out  1  registered negative flag
unsigned_overflow  out  1  registered carry/borrow flag
signed_overflow  out  1  registered two's-complement overflow flag
ram_addr  out  ADDR_W  RAM address
data_out  out  DATA_W  RAM write data, equal to bus_a

Behaviour:
- Reset (rst=1 at clk edge) overrides all enables. PC=0, IR=0 (decodes I_NOP), all registers=0, all four flags=0. ram_addr=0 in the cycle after reset; data_out=0.
- IR: loads data_in on ir_enable.
- Decoder (combinational on IR; unused fields=0):
  - 0x81 LOAD: c=IR[ADDR_W+RW-1:ADDR_W], mem_addr=IR[ADDR_W-1:0]
  - 0x82 STORE: a=same reg field, mem_addr as LOAD
  - 0x91 MOVE: a=b=IR[RW-1:0], c=IR[2RW-1:RW]
  - 0xA1/A2/A3/A4 ADD/SUB/AND/OR: a=IR[RW-1:0], b=IR[2RW-1:RW], c=IR[3RW-1:2RW]
  - 0x01/02/03 BRANCH/BZERO/BNEG: mem_addr=IR[ADDR_W-1:0]
  - 0x00 NOP, 0xFF HALT
  - Any other opcode decodes to I_NOP. The decoder never infers latches.
- PC: on pc_enable, PC <= branch ? mem_addr : PC+1, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0). Holds otherwise.
- ram_addr = addr_sel ? mem_addr : PC, combinational.
- Register file: two combinational read ports bus_a=RF[a], bus_b=RF[b]. One write port: on write_reg_enable, RF[c] <= c_sel ? alu_result : data_in. A same-cycle read of the register being written returns the old value; the new value is visible the next cycle.
- ALU, DATA_W wide with result truncated:
  - ADD: {carry,result} = a+b
  - SUB: result = a-b; borrow = (a<b unsigned)
  - AND/OR: bitwise; carry/borrow = 0 and signed overflow = 0
  - MOVE is issued by control as OR with a=b.
- Flags, computed combinationally from the ALU and loaded only on flags_reg_enable:
  - zero = (result==0)
  - neg = result[DATA_W-1]
  - unsigned_overflow = carry (ADD) or borrow (SUB)
  - signed_overflow: ADD = (a_msb==b_msb)&&(r_msb!=a_msb); SUB = (a_msb!=b_msb)&&(r_msb!=a_msb)
  - Flags hold between loads. Flag outputs come only from the register, never from the combinational values.
- Simultaneous strobes: all enables are independent and may coincide. An IR load in the same cycle as a PC/RF update uses the old IR decode for that update.
- Reset mid-instruction: all state is cleared in that cycle and no partial write survives.

Test Plan:
- Reset: hold rst 1 cycle with every enable=1 and data_in=16'hFFFF -> PC=0, all flags 0, decoded_instruction=I_NOP, ram_addr=0, RF[0..3]=0.
- LOAD/STORE: IR=16'h8145 (LOAD R2,M[5]), addr_sel=1 -> ram_addr=5. With data_in=16'h1234, c_sel=0, write -> RF[2]=16'h1234. Then IR=16'h8245 -> data_out=16'h1234, ram_addr=5.
- ADD overflow: R0=16'h7FFF, R1=16'h0001, IR=16'hA1B4 (R3=R0+R1), op=00, both enables -> R3=16'h8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB borrow/zero: R0=3, R1=5, SUB R2=R0-R1 -> R2=16'hFFFE, unsigned_overflow=1, neg=1. Then R1-R1 -> zero=1, all other flags 0. With flags_reg_enable=0 the flags hold.
- PC: pc_enable=1, branch=0 for 33 cycles from 0 -> PC wraps 31->0. Then IR=16'h0117, branch=1 -> PC=23.
- Parameter sweep: DATA_W=24, ADDR_W=8, NUM_REGS=8 -> ADD R7=R5+R6 with fields at [2:0],[5:3],[8:6] writes correctly. ADDR_W=12 with DATA_W=16 -> elaboration error.
